mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data requesters, routing in-order responses via a tag FIFO.
// Define MEM_ARB_FAIR_EN to force a fetch grant after STARVE_LIMIT consecutive data grants while fetch waits.
module mem_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_valid,
  input  logic [31:0] dm_addr,
  input  logic        dm_we,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_strb,
  output logic        dm_ready,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, HOLD_IF, HOLD_DM} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_DM} grant_t;

  state_t          state, state_next;
  grant_t          grant;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] tags;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            full, push, pop, head, fetch_first;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full uses the registered count only, so mem_rvalid never reaches mem_valid combinationally
  assign full = (count == CW'(DEPTH));

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [SW-1:0] starve_cnt;

  assign fetch_first = (starve_cnt >= SW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      starve_cnt <= '0;
    else if (!if_valid || if_ready)
      starve_cnt <= '0;
    else if (dm_ready && !fetch_first)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    grant = GNT_NONE;
    if (resetn) begin
      case (state)
        HOLD_IF: grant = GNT_IF;
        HOLD_DM: grant = GNT_DM;
        default: begin
          if (!full) begin
            if (fetch_first && if_valid) grant = GNT_IF;
            else if (dm_valid)           grant = GNT_DM;
            else if (if_valid)           grant = GNT_IF;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_strb  = '0;
    case (grant)
      GNT_IF: begin
        mem_valid = 1'b1;
        mem_addr  = if_addr;
      end
      GNT_DM: begin
        mem_valid = 1'b1;
        mem_addr  = dm_addr;
        mem_we    = dm_we;
        mem_wdata = dm_wdata;
        mem_strb  = dm_we ? dm_strb : 4'h0;
      end
      default: ;
    endcase
  end

  assign if_ready = mem_ready && (grant == GNT_IF);
  assign dm_ready = mem_ready && (grant == GNT_DM);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant == GNT_IF && !mem_ready) state_next = HOLD_IF;
        if (grant == GNT_DM && !mem_ready) state_next = HOLD_DM;
      end
      HOLD_IF, HOLD_DM: if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Responses with nothing outstanding are dropped rather than popping an empty FIFO
  assign push = mem_valid && mem_ready;
  assign pop  = mem_rvalid && (count != '0);
  assign head = tags[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tags   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= (grant == GNT_DM);
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign if_rvalid = pop && !head;
  assign dm_rvalid = pop && head;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule
